// File: rtl/mem_access_stage_pkg.sv
// mem_access_stage_pkg
// Shared constants and types for the memory-access pipeline stage:
//   - default data, register-address and memory-address widths
//   - FSM state encoding for the stage controller
package mem_access_stage_pkg;

  localparam int DSIZE_DEFAULT = 16;
  localparam int ASIZE_DEFAULT = 4;
  localparam int MAW_DEFAULT   = 8;

  // Stage controller states. The codes are fixed so the debug output can be
  // decoded by anything that watches it.
  typedef enum logic [1:0] {
    MS_IDLE = 2'd0,
    MS_BUSY = 2'd1,
    MS_DONE = 2'd2
  } ms_state_e;

endpackage

// File: rtl/mem_access_stage.sv
// mem_access_stage
// Memory-access stage between the EX/MEM register and MEM_WB_stage. It turns
// a load/store into a data-memory transaction, stalls the upstream pipeline
// until the access completes, and presents the write-back fields to MEM/WB.
// A timer aborts an access whose acknowledge never arrives.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   valid_in            EX/MEM holds a real instruction
//   alu_result_in       ALU result; low MAW bits are the memory word address
//   store_data_in       store data
//   waddr_in, wen_in    destination register and its write enable
//   memread_in          load (wins if memwrite_in is also set)
//   memwrite_in         store
//   mem_req/mem_we/mem_addr/mem_wdata  registered memory request fields
//   mem_ack, mem_rdata  one-cycle completion pulse and read data
//   result_out, waddr_out, wen_out, memtoreg_out  to MEM_WB_stage
//   stall_out           freezes PC, IF/ID, ID/EX and EX/MEM
//   mem_err_out         sticky timeout flag, cleared only by rst
//   state_dbg           current controller state (ms_state_e encoding)
//
// Handshake: mem_req rises on entry to BUSY and is held, together with
// mem_we/mem_addr/mem_wdata, unchanged until the cycle in which mem_ack is
// sampled high; mem_req drops the following cycle. mem_ack outside BUSY is
// ignored, and mem_rdata is only sampled in the ack cycle.
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int DSIZE   = DSIZE_DEFAULT,
  parameter int ASIZE   = ASIZE_DEFAULT,
  parameter int MAW     = MAW_DEFAULT,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_in,
  input  logic [DSIZE-1:0] alu_result_in,
  input  logic [DSIZE-1:0] store_data_in,
  input  logic [ASIZE-1:0] waddr_in,
  input  logic             wen_in,
  input  logic             memread_in,
  input  logic             memwrite_in,
  output logic             mem_req,
  output logic             mem_we,
  output logic [MAW-1:0]   mem_addr,
  output logic [DSIZE-1:0] mem_wdata,
  input  logic             mem_ack,
  input  logic [DSIZE-1:0] mem_rdata,
  output logic [DSIZE-1:0] result_out,
  output logic [ASIZE-1:0] waddr_out,
  output logic             wen_out,
  output logic             memtoreg_out,
  output logic             stall_out,
  output logic             mem_err_out,
  output logic [1:0]       state_dbg
);

  // Timer holds (BUSY cycles elapsed - 1) during BUSY, so hitting TIMEOUT-1
  // without an ack means this is the TIMEOUT-th BUSY cycle.
  localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

  ms_state_e        state;
  logic [7:0]       timer;
  logic [DSIZE-1:0] rdata_q;
  logic [ASIZE-1:0] waddr_q;
  logic             wen_q;
  logic             load_q;
  logic             abort_q;
  logic             memop;

  assign memop     = valid_in & (memread_in | memwrite_in);
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= MS_IDLE;
      timer       <= '0;
      rdata_q     <= '0;
      waddr_q     <= '0;
      wen_q       <= 1'b0;
      load_q      <= 1'b0;
      abort_q     <= 1'b0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_err_out <= 1'b0;
    end else begin
      case (state)
        MS_IDLE: begin
          if (memop) begin
            mem_addr  <= alu_result_in[MAW-1:0];
            mem_wdata <= store_data_in;
            mem_we    <= ~memread_in;
            load_q    <= memread_in;
            waddr_q   <= waddr_in;
            wen_q     <= wen_in;
            abort_q   <= 1'b0;
            timer     <= '0;
            mem_req   <= 1'b1;
            state     <= MS_BUSY;
          end
        end
        MS_BUSY: begin
          timer <= timer + 8'd1;
          if (mem_ack) begin
            if (load_q) rdata_q <= mem_rdata;
            mem_req <= 1'b0;
            state   <= MS_DONE;
          end else if (timer == TIMER_LAST) begin
            mem_err_out <= 1'b1;
            rdata_q     <= '0;
            abort_q     <= 1'b1;
            mem_req     <= 1'b0;
            state       <= MS_DONE;
          end
        end
        MS_DONE: begin
          state <= MS_IDLE;
        end
        default: begin
          state <= MS_IDLE;
        end
      endcase
    end
  end

  // Output mux: IDLE without a memop is a pure combinational pass-through so
  // ALU instructions see no added latency.
  always_comb begin
    result_out   = alu_result_in;
    waddr_out    = waddr_in;
    wen_out      = wen_in & valid_in;
    memtoreg_out = 1'b0;
    stall_out    = 1'b0;
    case (state)
      MS_IDLE: begin
        if (memop) begin
          stall_out = 1'b1;
          wen_out   = 1'b0;
        end
      end
      MS_BUSY: begin
        stall_out = 1'b1;
        wen_out   = 1'b0;
      end
      MS_DONE: begin
        waddr_out = waddr_q;
        if (load_q) begin
          result_out   = rdata_q;
          memtoreg_out = 1'b1;
          wen_out      = wen_q & ~abort_q;
        end else begin
          result_out = DSIZE'(mem_addr);
          wen_out    = 1'b0;
        end
      end
      default: begin
      end
    endcase
    if (rst) begin
      stall_out = 1'b0;
      wen_out   = 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage
// Directed bench for mem_access_stage: a vector table for the combinational
// pass-through paths, then hand-written sequences for load, store, timeout,
// reset mid-access and back-to-back accesses.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in;
  logic [15:0] alu_result_in;
  logic [15:0] store_data_in;
  logic [3:0]  waddr_in;
  logic        wen_in;
  logic        memread_in;
  logic        memwrite_in;
  logic        mem_req;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic [15:0] result_out;
  logic [3:0]  waddr_out;
  logic        wen_out;
  logic        memtoreg_out;
  logic        stall_out;
  logic        mem_err_out;
  logic [1:0]  state_dbg;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  mem_access_stage #(
    .DSIZE(16), .ASIZE(4), .MAW(8), .TIMEOUT(15)
  ) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in),
    .alu_result_in(alu_result_in), .store_data_in(store_data_in),
    .waddr_in(waddr_in), .wen_in(wen_in),
    .memread_in(memread_in), .memwrite_in(memwrite_in),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .result_out(result_out), .waddr_out(waddr_out), .wen_out(wen_out),
    .memtoreg_out(memtoreg_out), .stall_out(stall_out),
    .mem_err_out(mem_err_out), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // driver tasks
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drive_idle();
    valid_in      = 1'b0;
    memread_in    = 1'b0;
    memwrite_in   = 1'b0;
    wen_in        = 1'b0;
    alu_result_in = 16'h0000;
    store_data_in = 16'h0000;
    waddr_in      = 4'h0;
  endtask

  task automatic drive_op(input logic rd, input logic wr, input logic wen,
                          input logic [15:0] alu, input logic [15:0] data,
                          input logic [3:0] wa);
    valid_in      = 1'b1;
    memread_in    = rd;
    memwrite_in   = wr;
    wen_in        = wen;
    alu_result_in = alu;
    store_data_in = data;
    waddr_in      = wa;
  endtask

  // scoreboard compare
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic        valid;
    logic        wen;
    logic        rd;
    logic        wr;
    logic [15:0] alu;
    logic [3:0]  waddr;
    logic [15:0] exp_result;
    logic [3:0]  exp_waddr;
    logic        exp_wen;
    logic        exp_stall;
  } vec_t;

  vec_t vecs[6];

  int          busy_cnt;
  int          guard;
  int          done_cyc;
  int          busy_cyc;

  initial begin
    vecs[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h1234, 4'd3,  16'h1234, 4'd3,  1'b1, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'hABCD, 4'd7,  16'hABCD, 4'd7,  1'b0, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h5555, 4'd1,  16'h5555, 4'd1,  1'b0, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 16'h0005, 4'd2,  16'h0005, 4'd2,  1'b0, 1'b0};
    vecs[4] = '{1'b0, 1'b1, 1'b0, 1'b1, 16'hFFFF, 4'd15, 16'hFFFF, 4'd15, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 4'd0,  16'h0000, 4'd0,  1'b1, 1'b0};

    // Reset with a memop presented: stall and wen must stay forced low.
    rst       = 1'b1;
    mem_ack   = 1'b0;
    mem_rdata = 16'h0000;
    drive_op(1'b1, 1'b0, 1'b1, 16'h0077, 16'h0000, 4'd1);
    step();
    step();
    #1;
    chk("rst_stall", stall_out, 1'b0);
    chk("rst_wen", wen_out, 1'b0);
    chk("rst_state", state_dbg, 2'd0);
    chk("rst_req", mem_req, 1'b0);
    chk("rst_we", mem_we, 1'b0);
    chk("rst_addr", mem_addr, 8'h00);
    chk("rst_wdata", mem_wdata, 16'h0000);
    chk("rst_err", mem_err_out, 1'b0);
    drive_idle();
    rst = 1'b0;

    // Pass-through vectors (no memory access takes place).
    for (int i = 0; i < 6; i++) begin
      step();
      valid_in      = vecs[i].valid;
      wen_in        = vecs[i].wen;
      memread_in    = vecs[i].rd;
      memwrite_in   = vecs[i].wr;
      alu_result_in = vecs[i].alu;
      waddr_in      = vecs[i].waddr;
      #1;
      chk($sformatf("vec%0d_result", i), result_out, vecs[i].exp_result);
      chk($sformatf("vec%0d_waddr", i), waddr_out, vecs[i].exp_waddr);
      chk($sformatf("vec%0d_wen", i), wen_out, vecs[i].exp_wen);
      chk($sformatf("vec%0d_stall", i), stall_out, vecs[i].exp_stall);
      chk($sformatf("vec%0d_m2r", i), memtoreg_out, 1'b0);
      step();
      chk($sformatf("vec%0d_state", i), state_dbg, 2'd0);
      chk($sformatf("vec%0d_req", i), mem_req, 1'b0);
    end
    drive_idle();

    // Load at 0x05 (upper address bits ignored), ack in 2nd BUSY cycle.
    step();
    drive_op(1'b1, 1'b0, 1'b1, 16'hFF05, 16'h0000, 4'd5);
    #1;
    chk("ld_idle_stall", stall_out, 1'b1);
    chk("ld_idle_wen", wen_out, 1'b0);
    chk("ld_idle_req", mem_req, 1'b0);
    step(); #1;
    chk("ld_b1_state", state_dbg, 2'd1);
    chk("ld_b1_req", mem_req, 1'b1);
    chk("ld_b1_we", mem_we, 1'b0);
    chk("ld_b1_addr", mem_addr, 8'h05);
    chk("ld_b1_stall", stall_out, 1'b1);
    chk("ld_b1_wen", wen_out, 1'b0);
    step();
    mem_ack   = 1'b1;
    mem_rdata = 16'hBEEF;
    #1;
    chk("ld_b2_state", state_dbg, 2'd1);
    chk("ld_b2_req", mem_req, 1'b1);
    chk("ld_b2_stall", stall_out, 1'b1);
    step();
    mem_ack   = 1'b0;
    mem_rdata = 16'h0000;
    #1;
    chk("ld_done_state", state_dbg, 2'd2);
    chk("ld_done_stall", stall_out, 1'b0);
    chk("ld_done_result", result_out, 16'hBEEF);
    chk("ld_done_m2r", memtoreg_out, 1'b1);
    chk("ld_done_wen", wen_out, 1'b1);
    chk("ld_done_waddr", waddr_out, 4'd5);
    chk("ld_done_req", mem_req, 1'b0);
    chk("ld_done_err", mem_err_out, 1'b0);
    step();
    drive_idle();
    #1;
    chk("ld_back_idle", state_dbg, 2'd0);

    // Store 0x00AA to 0x10, ack in 1st BUSY cycle; wen_out low throughout.
    step();
    drive_op(1'b0, 1'b1, 1'b1, 16'h0010, 16'h00AA, 4'd8);
    #1;
    chk("st_idle_stall", stall_out, 1'b1);
    chk("st_idle_wen", wen_out, 1'b0);
    step();
    mem_ack = 1'b1;
    #1;
    chk("st_b1_state", state_dbg, 2'd1);
    chk("st_b1_we", mem_we, 1'b1);
    chk("st_b1_wdata", mem_wdata, 16'h00AA);
    chk("st_b1_addr", mem_addr, 8'h10);
    chk("st_b1_wen", wen_out, 1'b0);
    chk("st_b1_stall", stall_out, 1'b1);
    step();
    mem_ack = 1'b0;
    #1;
    chk("st_done_state", state_dbg, 2'd2);
    chk("st_done_stall", stall_out, 1'b0);
    chk("st_done_wen", wen_out, 1'b0);
    chk("st_done_m2r", memtoreg_out, 1'b0);
    chk("st_done_result", result_out, 16'h0010);
    chk("st_done_waddr", waddr_out, 4'd8);
    step();
    drive_idle();

    // Timeout: load with no ack must abort after exactly 15 BUSY cycles.
    step();
    drive_op(1'b1, 1'b0, 1'b1, 16'h0033, 16'h0000, 4'd9);
    step(); #1;
    busy_cnt = 0;
    guard    = 0;
    while (state_dbg == 2'd1 && guard < 40) begin
      if (mem_req === 1'b1) busy_cnt++;
      if (mem_err_out !== 1'b0) begin
        errors++;
        $display("FAIL to_early_err: got %0b expected 0 (cycle %0d)", mem_err_out, cyc);
      end
      step(); #1;
      guard++;
    end
    chk("to_bound", guard < 40, 1'b1);
    chk("to_busy_cycles", busy_cnt, 15);
    chk("to_done_state", state_dbg, 2'd2);
    chk("to_err", mem_err_out, 1'b1);
    chk("to_done_wen", wen_out, 1'b0);
    chk("to_done_result", result_out, 16'h0000);
    chk("to_done_m2r", memtoreg_out, 1'b1);
    chk("to_done_req", mem_req, 1'b0);
    step();
    drive_op(1'b0, 1'b0, 1'b1, 16'h4321, 16'h0000, 4'd2);
    #1;
    chk("to_after_result", result_out, 16'h4321);
    chk("to_after_wen", wen_out, 1'b1);
    step();
    step(); #1;
    chk("to_err_sticky", mem_err_out, 1'b1);
    drive_idle();

    // Reset in the 3rd BUSY cycle, then a late ack that must be ignored.
    step();
    drive_op(1'b1, 1'b0, 1'b1, 16'h0044, 16'h9999, 4'd3);
    step(); #1;
    chk("rm_b1_state", state_dbg, 2'd1);
    step();
    step();
    rst = 1'b1;
    drive_idle();
    #1;
    chk("rm_b3_state", state_dbg, 2'd1);
    chk("rm_b3_stall", stall_out, 1'b0);
    chk("rm_b3_wen", wen_out, 1'b0);
    step();
    rst       = 1'b0;
    mem_ack   = 1'b1;
    mem_rdata = 16'h1234;
    #1;
    chk("rm_state", state_dbg, 2'd0);
    chk("rm_req", mem_req, 1'b0);
    chk("rm_addr", mem_addr, 8'h00);
    chk("rm_we", mem_we, 1'b0);
    chk("rm_wdata", mem_wdata, 16'h0000);
    chk("rm_err", mem_err_out, 1'b0);
    step();
    mem_ack   = 1'b0;
    mem_rdata = 16'h0000;
    #1;
    chk("rm_ack_ignored_state", state_dbg, 2'd0);
    chk("rm_ack_ignored_req", mem_req, 1'b0);
    chk("rm_ack_ignored_stall", stall_out, 1'b0);

    // Back-to-back: load, then an op with both read and write set.
    step();
    drive_op(1'b1, 1'b0, 1'b1, 16'h0020, 16'h0000, 4'd4);
    step();
    mem_ack   = 1'b1;
    mem_rdata = 16'h1111;
    #1;
    chk("bb1_b1_state", state_dbg, 2'd1);
    step();
    mem_ack   = 1'b0;
    mem_rdata = 16'h0000;
    #1;
    done_cyc = cyc;
    chk("bb1_done_state", state_dbg, 2'd2);
    chk("bb1_done_result", result_out, 16'h1111);
    step();
    drive_op(1'b1, 1'b1, 1'b1, 16'h0021, 16'h7777, 4'd6);
    #1;
    chk("bb2_idle_state", state_dbg, 2'd0);
    chk("bb2_idle_stall", stall_out, 1'b1);
    step();
    #1;
    busy_cyc = cyc;
    chk("bb2_busy_state", state_dbg, 2'd1);
    chk("bb2_busy_gap", busy_cyc - done_cyc, 2);
    chk("bb2_busy_we", mem_we, 1'b0);
    chk("bb2_busy_addr", mem_addr, 8'h21);
    mem_ack   = 1'b1;
    mem_rdata = 16'h2222;
    step();
    mem_ack   = 1'b0;
    mem_rdata = 16'h0000;
    #1;
    chk("bb2_done_state", state_dbg, 2'd2);
    chk("bb2_done_result", result_out, 16'h2222);
    chk("bb2_done_m2r", memtoreg_out, 1'b1);
    chk("bb2_done_wen", wen_out, 1'b1);
    chk("bb2_done_waddr", waddr_out, 4'd6);
    step();
    drive_idle();
    step(); #1;
    chk("bb_end_state", state_dbg, 2'd0);

    // final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
